// File: rtl/iiitb_rv32i_pkg.sv
// Shared rv32i pipeline definitions: widths, opcode/funct3 encodings and the fetch FSM state type.
// Used by the fetch, decode, EX, MEM and WB stages.
package iiitb_rv32i_pkg;

    localparam int XLEN = 32;

    // opcode field, bits [6:0] of the instruction word
    localparam logic [6:0] AR_TYPE = 7'd0;
    localparam logic [6:0] M_TYPE  = 7'd1;
    localparam logic [6:0] BR_TYPE = 7'd2;
    localparam logic [6:0] SH_TYPE = 7'd3;

    localparam logic [2:0] F3_ADD = 3'd0;
    localparam logic [2:0] F3_SUB = 3'd1;
    localparam logic [2:0] F3_AND = 3'd2;
    localparam logic [2:0] F3_OR  = 3'd3;
    localparam logic [2:0] F3_XOR = 3'd4;
    localparam logic [2:0] F3_SLT = 3'd5;
    localparam logic [2:0] F3_BEQ = 3'd0;
    localparam logic [2:0] F3_BNE = 3'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } ifu_state_t;

    function automatic logic [6:0] get_opcode(input logic [XLEN-1:0] ir);
        return ir[6:0];
    endfunction

endpackage

// File: rtl/iiitb_rv32i_fetch_fifo.sv
// Prefetch queue holding {IR, NPC} pairs; head is read straight from storage.
// Flush beats push/pop; push and pop may coincide at any fill level.
module iiitb_rv32i_fetch_fifo #(
    parameter  int W     = 64,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rn,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [W-1:0]  i_wdata,
    output logic [PW:0]   o_count,
    output logic [W-1:0]  o_head
);

    localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != C_FULL) || w_pop);

    always_ff @(posedge i_clk or negedge i_rn) begin
        if (!i_rn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    // stale storage is masked so an empty queue always presents zeros
    assign o_head  = (r_count != '0) ? r_mem[r_rptr] : '0;

endmodule

// File: rtl/iiitb_rv32i_ifu.sv
// rv32i instruction fetch: IMEM, word PC, fetch FSM and prefetch queue feeding decode.
//   state | meaning
//   IDLE  | not issuing (fetch_en low), queue drains; redirects still load PC
//   RUN   | issuing one IMEM read per cycle while queue credit remains
//   HALT  | PC has left IMEM; waits for a redirect
module iiitb_rv32i_ifu
    import iiitb_rv32i_pkg::*;
#(
    parameter  int IMEM_DEPTH = 64,
    parameter  int QDEPTH     = 4,
    localparam int AW         = $clog2(IMEM_DEPTH),
    localparam int CW         = $clog2(QDEPTH) + 1
) (
    input  logic            i_clk,
    input  logic            i_rn,
    input  logic            i_imem_we,
    input  logic [AW-1:0]   i_imem_waddr,
    input  logic [XLEN-1:0] i_imem_wdata,
    input  logic            i_fetch_en,
    input  logic            i_br_en,
    input  logic [XLEN-1:0] i_br_target,
    output logic            o_if_valid,
    input  logic            i_if_ready,
    output logic [XLEN-1:0] o_if_ir,
    output logic [XLEN-1:0] o_if_npc,
    output logic [XLEN-1:0] o_pc,
    output logic            o_halted
);

    localparam logic [XLEN-1:0] C_DEPTH = XLEN'(IMEM_DEPTH);
    localparam logic [XLEN-1:0] C_LAST  = XLEN'(IMEM_DEPTH - 1);
    localparam logic [CW-1:0]   C_QD    = CW'(QDEPTH);

    logic [XLEN-1:0]   r_mem [IMEM_DEPTH];
    logic [XLEN-1:0]   r_rdata;
    logic [XLEN-1:0]   r_rnpc;
    logic [XLEN-1:0]   r_pc;
    ifu_state_t        r_state;
    ifu_state_t        w_state_nxt;
    logic              r_epoch;
    logic              r_inflight;
    logic              r_inf_epoch;

    logic [XLEN-1:0]   w_pc_inc;
    logic              w_in_range;
    logic              w_credit;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_count;
    logic [2*XLEN-1:0] w_head;

    assign w_pc_inc     = r_pc + XLEN'(1);
    assign w_in_range   = (r_pc < C_DEPTH);
    // in-flight read holds a slot so a full queue can never be overrun
    assign w_credit     = ((w_count + CW'(r_inflight)) < C_QD);
    assign w_issue      = i_fetch_en && !i_br_en && (r_state != HALT) && w_in_range && w_credit;
    assign w_last_issue = w_issue && (r_pc == C_LAST);
    assign w_push       = r_inflight && (r_inf_epoch == r_epoch) && !i_br_en;
    assign w_pop        = o_if_valid && i_if_ready && !i_br_en;

    // IMEM is deliberately unreset; the registered read sees pre-write contents
    always_ff @(posedge i_clk) begin
        if (i_imem_we && i_rn) r_mem[i_imem_waddr] <= i_imem_wdata;
        if (w_issue)           r_rdata <= r_mem[r_pc[AW-1:0]];
    end

    always_ff @(posedge i_clk or negedge i_rn) begin
        if (!i_rn) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_epoch     <= 1'b0;
            r_inflight  <= 1'b0;
            r_inf_epoch <= 1'b0;
            r_rnpc      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if (i_br_en) begin
                r_pc    <= i_br_target;
                r_epoch <= ~r_epoch;
            end else if (w_issue) begin
                r_pc <= w_pc_inc;
            end
            if (w_issue) begin
                r_inf_epoch <= r_epoch;
                r_rnpc      <= w_pc_inc;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_br_en) begin
            w_state_nxt = (r_state == IDLE) ? IDLE : RUN;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_fetch_en) w_state_nxt = (w_last_issue || !w_in_range) ? HALT : RUN;
                end
                RUN: begin
                    if (!i_fetch_en)                     w_state_nxt = IDLE;
                    else if (w_last_issue || !w_in_range) w_state_nxt = HALT;
                end
                HALT:    w_state_nxt = HALT;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    iiitb_rv32i_fetch_fifo #(
        .W     (2*XLEN),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rn    (i_rn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_br_en),
        .i_wdata ({r_rdata, r_rnpc}),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign o_if_valid = (w_count != '0);
    assign o_if_ir    = w_head[2*XLEN-1:XLEN];
    assign o_if_npc   = w_head[XLEN-1:0];
    assign o_pc       = r_pc;
    assign o_halted   = (r_state == HALT);

endmodule

// File: tb/tb_iiitb_rv32i_ifu.sv
// Directed bench for the rv32i fetch unit, plus a randomized ready/redirect stretch checked
// against the expected in-order PC sequence.
module tb_iiitb_rv32i_ifu;

    logic        clk = 1'b0;
    logic        rn = 1'b0;
    logic        imem_we = 1'b0;
    logic [5:0]  imem_waddr = '0;
    logic [31:0] imem_wdata = '0;
    logic        fetch_en = 1'b0;
    logic        br_en = 1'b0;
    logic [31:0] br_target = '0;
    logic        if_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_ir;
    logic [31:0] if_npc;
    logic [31:0] pc;
    logic        halted;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] prog [64];

    always #5 clk = ~clk;

    iiitb_rv32i_ifu dut (
        .i_clk        (clk),
        .i_rn         (rn),
        .i_imem_we    (imem_we),
        .i_imem_waddr (imem_waddr),
        .i_imem_wdata (imem_wdata),
        .i_fetch_en   (fetch_en),
        .i_br_en      (br_en),
        .i_br_target  (br_target),
        .o_if_valid   (if_valid),
        .i_if_ready   (if_ready),
        .o_if_ir      (if_ir),
        .o_if_npc     (if_npc),
        .o_pc         (pc),
        .o_halted     (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rn = 1'b0;
        fetch_en = 1'b0;
        if_ready = 1'b0;
        br_en = 1'b0;
        @(negedge clk);
        rn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_npc;
        int pops;

        prog[0]  = 32'h02208300;  prog[1]  = 32'h02209380;
        prog[2]  = 32'h0230a400;  prog[3]  = 32'h02513480;
        prog[4]  = 32'h0240c500;  prog[5]  = 32'h02415580;
        prog[6]  = 32'h00520600;  prog[7]  = 32'h00209181;
        prog[8]  = 32'h00208681;  prog[9]  = 32'h00f00002;
        prog[10] = 32'h00210700;  prog[11] = 32'h01409002;
        prog[12] = 32'h00520601;  prog[13] = 32'h00f00003;
        for (int i = 14; i < 64; i++) prog[i] = 32'hC0DE0000 + i;

        // reset values
        rn = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_ir", if_ir, 32'd0);
        check("rst_npc", if_npc, 32'd0);

        rn = 1'b1;
        imem_we = 1'b1;
        for (int i = 0; i < 64; i++) begin
            imem_waddr = 6'(i);
            imem_wdata = prog[i];
            @(negedge clk);
        end
        imem_we = 1'b0;
        check("idle_pc", pc, 32'd0);
        check("idle_valid", 32'(if_valid), 32'd0);

        // first fetch: gapless program stream from cycle 2
        fetch_en = 1'b1;
        if_ready = 1'b1;
        @(negedge clk);
        check("a_bubble", 32'(if_valid), 32'd0);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            check("a_valid", 32'(if_valid), 32'd1);
            check("a_ir", if_ir, prog[k]);
            check("a_npc", if_npc, 32'(k + 1));
        end

        // back-pressure: queue fills to 4 and pc stops at 4
        do_reset();
        fetch_en = 1'b1;
        if_ready = 1'b0;
        repeat (10) @(negedge clk);
        check("b_pc_hold", pc, 32'd4);
        check("b_valid", 32'(if_valid), 32'd1);
        check("b_head", if_ir, prog[0]);
        if_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            check("b_valid_rel", 32'(if_valid), 32'd1);
            check("b_ir", if_ir, prog[k]);
            check("b_npc", if_npc, 32'(k + 1));
        end

        // redirect at cycle 6 to word 11
        do_reset();
        fetch_en = 1'b1;
        if_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("c_pre_ir", if_ir, prog[4]);
        br_en = 1'b1;
        br_target = 32'd11;
        @(negedge clk);
        br_en = 1'b0;
        check("c_bubble1", 32'(if_valid), 32'd0);
        check("c_pc", pc, 32'd11);
        @(negedge clk);
        check("c_bubble2", 32'(if_valid), 32'd0);
        @(negedge clk);
        check("c_valid", 32'(if_valid), 32'd1);
        check("c_ir", if_ir, prog[11]);
        check("c_npc", if_npc, 32'd12);

        // run off the end of IMEM
        exp_npc = 13;
        for (int cyc = 0; cyc < 200 && exp_npc <= 64; cyc++) begin
            @(negedge clk);
            if (if_valid) begin
                check("d_ir", if_ir, prog[exp_npc - 1]);
                check("d_npc", if_npc, 32'(exp_npc));
                exp_npc++;
            end
        end
        check("d_reached_end", 32'(exp_npc), 32'd65);
        check("d_halted", 32'(halted), 32'd1);
        check("d_pc_end", pc, 32'd64);
        @(negedge clk);
        check("d_drained", 32'(if_valid), 32'd0);
        check("d_pc_stuck", pc, 32'd64);
        br_en = 1'b1;
        br_target = 32'd0;
        @(negedge clk);
        br_en = 1'b0;
        check("d_unhalt", 32'(halted), 32'd0);
        check("d_bub1", 32'(if_valid), 32'd0);
        @(negedge clk);
        check("d_bub2", 32'(if_valid), 32'd0);
        @(negedge clk);
        check("d_re_ir", if_ir, prog[0]);
        check("d_re_npc", if_npc, 32'd1);

        // async reset mid-stream with 3 queued; writes ignored while in reset
        do_reset();
        fetch_en = 1'b1;
        if_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("e_valid_pre", 32'(if_valid), 32'd1);
        imem_we = 1'b1;
        imem_waddr = 6'd0;
        imem_wdata = 32'hDEADBEEF;
        rn = 1'b0;
        #1;
        check("e_rst_valid", 32'(if_valid), 32'd0);
        check("e_rst_pc", pc, 32'd0);
        check("e_rst_ir", if_ir, 32'd0);
        @(negedge clk);
        imem_we = 1'b0;
        rn = 1'b1;
        if_ready = 1'b1;
        @(negedge clk);
        check("e_bubble", 32'(if_valid), 32'd0);
        @(negedge clk);
        check("e_ir", if_ir, prog[0]);
        check("e_npc", if_npc, 32'd1);

        // write to word 0 in the same cycle it is read: old data returned
        do_reset();
        fetch_en = 1'b1;
        if_ready = 1'b1;
        imem_we = 1'b1;
        imem_waddr = 6'd0;
        imem_wdata = 32'h13579BDF;
        @(negedge clk);
        imem_we = 1'b0;
        check("g_bubble", 32'(if_valid), 32'd0);
        @(negedge clk);
        check("g_old_ir", if_ir, prog[0]);
        prog[0] = 32'h13579BDF;

        // random ready and redirects against the expected PC sequence
        do_reset();
        fetch_en = 1'b1;
        exp_npc = 1;
        pops = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if_ready = 1'($urandom_range(0, 1));
            br_en = ($urandom_range(0, 15) == 0);
            br_target = 32'($urandom_range(0, 63));
            if (br_en) begin
                exp_npc = int'(br_target) + 1;
            end else if (if_valid && if_ready) begin
                check("f_ir", if_ir, prog[(exp_npc - 1) & 63]);
                check("f_npc", if_npc, 32'(exp_npc));
                exp_npc++;
                pops++;
            end
        end
        @(negedge clk);
        br_en = 1'b0;
        if_ready = 1'b0;
        check("f_enough_pops", 32'(pops > 1000), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
